// File: rtl/prng_uart_pkg.sv
// prng_uart_pkg: shared state encoding and byte-order helper for the PRNG-to-UART feeder
package prng_uart_pkg;

    typedef enum logic [1:0] {
        FEED_IDLE = 2'd0,
        FEED_REQ  = 2'd1,
        FEED_REL  = 2'd2
    } feed_state_t;

    // Maps the transmit-order index onto the byte lane of the word
    function automatic int byte_sel(input bit msb_first, input int bytes, input int idx);
        return msb_first ? bytes - 1 - idx : idx;
    endfunction

endpackage

// File: rtl/prng_uart_feeder.sv
// prng_uart_feeder: splits PRNG words into bytes and hands them to uart_tx with stall detection
module prng_uart_feeder
    import prng_uart_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              parity_en,
    output logic              tx_ready,
    input  logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_parity,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int BYTES = WORD_W / 8;
    localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC);

    feed_state_t       state;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  byte_idx;
    logic [TO_W-1:0]   to_cnt;
    logic              last;
    logic              timeout_hit;
    logic              req_done;
    logic              rel_done;
    logic              accept;
    logic              moving;

    assign last        = byte_idx == IDX_W'(BYTES - 1);
    assign timeout_hit = state != FEED_IDLE && to_cnt == TO_W'(TIMEOUT_CYC - 1);
    assign req_done    = state == FEED_REQ && tx_valid;
    assign rel_done    = state == FEED_REL && !tx_valid;
    assign in_ready    = state == FEED_IDLE || (rel_done && last && !timeout_hit);
    assign accept      = in_valid && in_ready;
    assign moving      = req_done || rel_done || timeout_hit;
    assign busy        = state != FEED_IDLE;

    // Cycles spent waiting on the current handshake edge; restarts on every state change
    always_ff @(posedge clk) begin
        if (ap_rst || state == FEED_IDLE || moving)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // Handshake FSM with registered uart_tx-facing outputs; a stall abort outranks everything
    always_ff @(posedge clk) begin
        if (ap_rst) begin
            state       <= FEED_IDLE;
            word        <= '0;
            byte_idx    <= '0;
            tx_ready    <= 1'b0;
            tx_data     <= 8'h00;
            tx_parity   <= 1'b0;
            err_timeout <= 1'b0;
            words_sent  <= '0;
        end else begin
            if (timeout_hit)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
            if (rel_done && last && !timeout_hit)
                words_sent <= words_sent + 1'b1;
            if (timeout_hit) begin
                state    <= FEED_IDLE;
                tx_ready <= 1'b0;
                byte_idx <= '0;
            end else if (accept) begin
                word      <= in_data;
                tx_parity <= parity_en;
                byte_idx  <= '0;
                tx_data   <= in_data[8*byte_sel(MSB_FIRST, BYTES, 0) +: 8];
                tx_ready  <= 1'b1;
                state     <= FEED_REQ;
            end else if (req_done) begin
                tx_ready <= 1'b0;
                state    <= FEED_REL;
            end else if (rel_done) begin
                if (last) begin
                    state <= FEED_IDLE;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                    tx_data  <= word[8*byte_sel(MSB_FIRST, BYTES, int'(byte_idx) + 1) +: 8];
                    tx_ready <= 1'b1;
                    state    <= FEED_REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_prng_uart_feeder.sv
// tb_prng_uart_feeder: directed vectors plus corner sequences for the PRNG-to-UART feeder
module tb_prng_uart_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ap_rst, in_valid, parity_en, err_clr;
    logic [31:0] in_data;
    logic        in_ready0, tx_ready0, tx_valid0, tx_parity0, busy0, err0;
    logic [7:0]  tx_data0;
    logic [15:0] ws0;
    logic        in_ready1, tx_ready1, tx_valid1, tx_parity1, busy1, err1;
    logic [7:0]  tx_data1;
    logic [1:0]  ws1;

    prng_uart_feeder #(.WORD_W(32), .MSB_FIRST(1'b1), .TIMEOUT_CYC(64), .CNT_W(16)) dut0 (
        .clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .parity_en(parity_en), .tx_ready(tx_ready0), .tx_valid(tx_valid0), .tx_data(tx_data0),
        .tx_parity(tx_parity0), .busy(busy0), .err_timeout(err0), .err_clr(err_clr), .words_sent(ws0)
    );

    prng_uart_feeder #(.WORD_W(32), .MSB_FIRST(1'b0), .TIMEOUT_CYC(64), .CNT_W(2)) dut1 (
        .clk(clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .parity_en(parity_en), .tx_ready(tx_ready1), .tx_valid(tx_valid1), .tx_data(tx_data1),
        .tx_parity(tx_parity1), .busy(busy1), .err_timeout(err1), .err_clr(err_clr), .words_sent(ws1)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ws_model = 0;
    bit         ack_en   = 1'b0;
    logic [8:0] log0[$];
    logic [8:0] log1[$];

    typedef struct {
        logic [31:0] w;
        logic        p;
        logic [31:0] msb;
        logic [31:0] lsb;
    } vec_t;
    vec_t vecs[5];

    // uart_tx stand-in: acknowledges each byte one cycle after tx_ready and logs {parity, data}
    always @(posedge clk) begin
        #2;
        if (ack_en) begin
            if (tx_ready0 && !tx_valid0) begin
                tx_valid0 = 1'b1;
                log0.push_back({tx_parity0, tx_data0});
            end else if (!tx_ready0 && tx_valid0) begin
                tx_valid0 = 1'b0;
            end
            if (tx_ready1 && !tx_valid1) begin
                tx_valid1 = 1'b1;
                log1.push_back({tx_parity1, tx_data1});
            end else if (!tx_ready1 && tx_valid1) begin
                tx_valid1 = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (in_ready0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic p);
        bit ok;
        in_valid  = 1'b1;
        in_data   = w;
        parity_en = p;
        wait_ready(ok);
        check("accept_wait", 32'(ok), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy0 && !tx_valid0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("idle_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          ok;
        logic [31:0] e;
        logic [63:0] e64;
        vecs[0] = '{32'hA5C30F81, 1'b1, 32'hA5C30F81, 32'h810FC3A5};
        vecs[1] = '{32'h11223344, 1'b0, 32'h11223344, 32'h44332211};
        vecs[2] = '{32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'hEFBEADDE};
        vecs[3] = '{32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
        vecs[4] = '{32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        ap_rst = 1'b1; in_valid = 1'b0; in_data = '0; parity_en = 1'b0; err_clr = 1'b0;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready0), 32'd0);
        check("rst_tx_data", 32'(tx_data0), 32'd0);
        check("rst_tx_parity", 32'(tx_parity0), 32'd0);
        check("rst_err", 32'(err0), 32'd0);
        check("rst_words", 32'(ws0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        ap_rst = 1'b0;
        ack_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            log0.delete(); log1.delete();
            send_word(vecs[i].w, vecs[i].p);
            wait_idle();
            ws_model++;
            check($sformatf("vec%0d_count_msb", i), 32'(log0.size()), 32'd4);
            check($sformatf("vec%0d_count_lsb", i), 32'(log1.size()), 32'd4);
            for (int k = 0; k < 4; k++) begin
                e = vecs[i].msb;
                check($sformatf("vec%0d_msb_byte%0d", i, k), 32'(log0[k]), 32'({vecs[i].p, e[31-8*k -: 8]}));
                e = vecs[i].lsb;
                check($sformatf("vec%0d_lsb_byte%0d", i, k), 32'(log1[k]), 32'({vecs[i].p, e[31-8*k -: 8]}));
            end
            check($sformatf("vec%0d_words", i), 32'(ws0), 32'(ws_model));
            check($sformatf("vec%0d_words_wrap", i), 32'(ws1), 32'(ws_model % 4));
        end

        log0.delete(); log1.delete();
        in_valid = 1'b1; in_data = 32'hA5C30F81; parity_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; parity_en = 1'b0;
        check("latency_tx_ready", 32'(tx_ready0), 32'd1);
        check("latency_tx_data_msb", 32'(tx_data0), 32'hA5);
        check("latency_tx_data_lsb", 32'(tx_data1), 32'h81);
        check("latency_parity", 32'(tx_parity0), 32'd1);
        check("latency_busy", 32'(busy0), 32'd1);
        wait_idle();
        ws_model++;
        for (int k = 0; k < 4; k++)
            check($sformatf("par_hold_byte%0d", k), 32'(log0[k][8]), 32'd1);
        check("par_hold_words", 32'(ws0), 32'(ws_model));
        log0.delete(); log1.delete();
        send_word(32'h01020304, 1'b0);
        wait_idle();
        ws_model++;
        check("par_next_word", 32'(log0[0]), 32'h001);

        log0.delete(); log1.delete();
        in_valid = 1'b1; in_data = 32'h11223344; parity_en = 1'b0;
        wait_ready(ok);
        @(negedge clk);
        in_data = 32'h55667788;
        wait_ready(ok);
        check("b2b_ready_seen", 32'(ok), 32'd1);
        check("b2b_ready_on_last", 32'(tx_data0), 32'h44);
        check("b2b_no_idle", 32'(busy0), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_tx_ready", 32'(tx_ready0), 32'd1);
        check("b2b_tx_data", 32'(tx_data0), 32'h55);
        wait_idle();
        ws_model += 2;
        check("b2b_words", 32'(ws0), 32'(ws_model));
        e64 = 64'h1122334455667788;
        for (int k = 0; k < 8; k++)
            check($sformatf("b2b_byte%0d", k), 32'(log0[k]), 32'({1'b0, e64[63-8*k -: 8]}));

        ack_en = 1'b0;
        in_valid = 1'b1; in_data = 32'hCAFEF00D; parity_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("to_tx_ready_up", 32'(tx_ready0), 32'd1);
        repeat (63) @(negedge clk);
        check("to_not_yet", 32'(err0), 32'd0);
        check("to_still_req", 32'(tx_ready0), 32'd1);
        @(negedge clk);
        check("to_err", 32'(err0), 32'd1);
        check("to_err_lsb", 32'(err1), 32'd1);
        check("to_tx_ready", 32'(tx_ready0), 32'd0);
        check("to_in_ready", 32'(in_ready0), 32'd1);
        check("to_busy", 32'(busy0), 32'd0);
        check("to_words", 32'(ws0), 32'(ws_model));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_clear", 32'(err0), 32'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; err_clr = 1'b1;
        repeat (64) @(negedge clk);
        check("to_set_wins", 32'(err0), 32'd1);
        @(negedge clk);
        check("to_clr_after", 32'(err0), 32'd0);
        err_clr = 1'b0;
        ack_en = 1'b1;

        log0.delete(); log1.delete();
        send_word(32'h9ABCDEF0, 1'b1);
        for (int i = 0; i < 50 && log0.size() < 2; i++) @(negedge clk);
        check("rst_mid_reached", 32'(log0.size()), 32'd2);
        ap_rst = 1'b1;
        @(negedge clk);
        ap_rst = 1'b0;
        ws_model = 0;
        check("rst_mid_tx_ready", 32'(tx_ready0), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data0), 32'd0);
        check("rst_mid_tx_data_lsb", 32'(tx_data1), 32'd0);
        check("rst_mid_parity", 32'(tx_parity0), 32'd0);
        check("rst_mid_words", 32'(ws0), 32'd0);
        check("rst_mid_busy", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        log0.delete(); log1.delete();
        send_word(32'h13579BDF, 1'b0);
        wait_idle();
        ws_model++;
        e = 32'h13579BDF;
        for (int k = 0; k < 4; k++)
            check($sformatf("post_rst_byte%0d", k), 32'(log0[k]), 32'({1'b0, e[31-8*k -: 8]}));
        check("post_rst_words", 32'(ws0), 32'(ws_model));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
